// File: rtl/alien_kill_ctrl.sv
// Per-frame alien kill controller: arms the hit-checker on each active-laser frame,
// answers its alive queries, and applies kills to the formation, score and kill count.
module alien_kill_ctrl #(
  parameter int NUM_ALIENS       = 20,
  parameter int POINTS_PER_ALIEN = 10,
  parameter int SCORE_WIDTH      = 12,
  parameter int CHECK_TIMEOUT    = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic                   laser_active,
  input  logic                   new_wave,
  input  logic [4:0]             which_alien_out,
  input  logic                   check_done,
  input  logic                   check_killed,
  output logic                   alien_check_reset,
  output logic                   alien_alive,
  output logic [NUM_ALIENS-1:0]  alive_mask,
  output logic [SCORE_WIDTH-1:0] score,
  output logic [4:0]             kill_count,
  output logic                   all_dead,
  output logic                   laser_hit,
  output logic                   busy,
  output logic                   frame_overrun,
  output logic                   check_timeout
);

  localparam int TIMER_W = $clog2(CHECK_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_KILL = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 next_state_s;
  logic [TIMER_W-1:0]     timer_r;
  logic [NUM_ALIENS-1:0]  alive_mask_r;
  logic [SCORE_WIDTH-1:0] score_r;
  logic [4:0]             kill_count_r;
  logic                   wave_pending_r;
  logic                   frame_overrun_r;
  logic                   check_timeout_r;
  logic                   check_reset_r;

  logic [31:0]            alive_pad_s;
  logic                   idx_alive_s;
  logic                   all_dead_s;
  logic                   busy_s;
  logic                   restore_s;
  logic                   kill_s;
  logic                   timeout_s;
  logic                   hold_checker_s;
  logic                   laser_hit_s;
  logic [NUM_ALIENS-1:0]  kill_mask_s;
  logic [SCORE_WIDTH:0]   score_sum_s;
  logic [SCORE_WIDTH-1:0] score_next_s;

  // Zero-padding to the full 5-bit index range makes out-of-range indices read as dead.
  assign alive_pad_s = {{(32-NUM_ALIENS){1'b0}}, alive_mask_r};
  assign idx_alive_s = alive_pad_s[which_alien_out];
  assign all_dead_s  = (alive_mask_r == {NUM_ALIENS{1'b0}});
  assign busy_s      = (state_r != S_IDLE);

  assign alien_check_reset = check_reset_r;
  assign alien_alive       = idx_alive_s;
  assign alive_mask        = alive_mask_r;
  assign score             = score_r;
  assign kill_count        = kill_count_r;
  assign all_dead          = all_dead_s;
  assign laser_hit         = laser_hit_s;
  assign busy              = busy_s;
  assign frame_overrun     = frame_overrun_r;
  assign check_timeout     = check_timeout_r;

  // One-hot clear mask and saturating score increment for the kill update
  always_comb begin
    kill_mask_s = {NUM_ALIENS{1'b0}};
    for (int i = 0; i < NUM_ALIENS; i++) begin
      kill_mask_s[i] = (which_alien_out == 5'(i));
    end
    score_sum_s = {1'b0, score_r} + (SCORE_WIDTH+1)'(POINTS_PER_ALIEN);
    if (score_sum_s[SCORE_WIDTH]) begin
      score_next_s = {SCORE_WIDTH{1'b1}};
    end else begin
      score_next_s = score_sum_s[SCORE_WIDTH-1:0];
    end
  end

  // Next-state and per-state control strobes
  always_comb begin
    next_state_s   = state_r;
    restore_s      = 1'b0;
    kill_s         = 1'b0;
    timeout_s      = 1'b0;
    laser_hit_s    = 1'b0;
    hold_checker_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        // A wave restore owns the cycle; a coincident frame_tick is dropped.
        if (new_wave || wave_pending_r) begin
          restore_s    = 1'b1;
          next_state_s = S_IDLE;
        end else if (frame_tick && laser_active && !all_dead_s) begin
          next_state_s = S_ARM;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_ARM: begin
        next_state_s = S_RUN;
      end
      S_RUN: begin
        if (check_done && check_killed) begin
          next_state_s = S_KILL;
        end else if (check_done) begin
          next_state_s = S_IDLE;
        end else if (timer_r == TIMER_W'(CHECK_TIMEOUT-1)) begin
          timeout_s    = 1'b1;
          next_state_s = S_IDLE;
        end else begin
          next_state_s = S_RUN;
        end
      end
      S_KILL: begin
        if (idx_alive_s) begin
          kill_s      = 1'b1;
          laser_hit_s = 1'b1;
        end else begin
          kill_s      = 1'b0;
          laser_hit_s = 1'b0;
        end
        next_state_s = S_IDLE;
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
    if ((next_state_s == S_IDLE) || (next_state_s == S_ARM)) begin
      hold_checker_s = 1'b1;
    end else begin
      hold_checker_s = 1'b0;
    end
  end

  // State register and registered checker hold
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= S_IDLE;
      check_reset_r <= 1'b1;
    end else begin
      state_r       <= next_state_s;
      check_reset_r <= hold_checker_s;
    end
  end

  // Formation, score, timer and sticky status registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alive_mask_r    <= {NUM_ALIENS{1'b1}};
      score_r         <= {SCORE_WIDTH{1'b0}};
      kill_count_r    <= 5'd0;
      wave_pending_r  <= 1'b0;
      frame_overrun_r <= 1'b0;
      check_timeout_r <= 1'b0;
      timer_r         <= {TIMER_W{1'b0}};
    end else begin
      if (busy_s && frame_tick) begin
        frame_overrun_r <= 1'b1;
      end
      if (timeout_s) begin
        check_timeout_r <= 1'b1;
      end
      if (restore_s) begin
        wave_pending_r <= 1'b0;
      end else if (busy_s && new_wave) begin
        wave_pending_r <= 1'b1;
      end
      if (restore_s) begin
        alive_mask_r <= {NUM_ALIENS{1'b1}};
        kill_count_r <= 5'd0;
      end else if (kill_s) begin
        alive_mask_r <= alive_mask_r & ~kill_mask_s;
        kill_count_r <= kill_count_r + 5'd1;
        score_r      <= score_next_s;
      end
      if (state_r == S_ARM) begin
        timer_r <= {TIMER_W{1'b0}};
      end else if (state_r == S_RUN) begin
        timer_r <= timer_r + TIMER_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alien_kill_ctrl.sv
// Self-checking bench for alien_kill_ctrl: vector table plus scoreboard queue,
// with hand-written sequences for overrun, timeout, wave restore and mid-operation reset.
module tb_alien_kill_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        laser_active;
  logic        new_wave;
  logic [4:0]  which_alien_out;
  logic        check_done;
  logic        check_killed;
  logic        alien_check_reset;
  logic        alien_alive;
  logic [19:0] alive_mask;
  logic [11:0] score;
  logic [4:0]  kill_count;
  logic        all_dead;
  logic        laser_hit;
  logic        busy;
  logic        frame_overrun;
  logic        check_timeout;

  alien_kill_ctrl dut (
    .clock             (clock),
    .reset             (reset),
    .frame_tick        (frame_tick),
    .laser_active      (laser_active),
    .new_wave          (new_wave),
    .which_alien_out   (which_alien_out),
    .check_done        (check_done),
    .check_killed      (check_killed),
    .alien_check_reset (alien_check_reset),
    .alien_alive       (alien_alive),
    .alive_mask        (alive_mask),
    .score             (score),
    .kill_count        (kill_count),
    .all_dead          (all_dead),
    .laser_hit         (laser_hit),
    .busy              (busy),
    .frame_overrun     (frame_overrun),
    .check_timeout     (check_timeout)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [19:0] mask;
    logic [11:0] score;
    logic [4:0]  kills;
    int          hits;
  } exp_t;

  typedef struct {
    logic        la;
    int          delay;
    logic        killed;
    logic [4:0]  idx;
    logic [19:0] mask;
    logic [11:0] score;
    logic [4:0]  kills;
    int          hits;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Launch one frame and act as the checker; delay < 0 means never report done.
  task automatic do_frame(input logic la, input int delay, input logic killed,
                          input logic [4:0] idx, input logic inject,
                          output int hits, output int run_cycles);
    logic done_sent;
    logic ended;
    hits = 0;
    run_cycles = 0;
    done_sent = 1'b0;
    ended = 1'b0;
    laser_active = la;
    which_alien_out = idx;
    frame_tick = 1'b1;
    tick();
    for (int c = 0; c < 80; c++) begin
      frame_tick = 1'b0;
      new_wave = 1'b0;
      if (!busy) begin
        ended = 1'b1;
        break;
      end
      if (laser_hit) hits++;
      if (!alien_check_reset && !done_sent) begin
        run_cycles++;
        if (inject && run_cycles == 2) begin
          frame_tick = 1'b1;
          new_wave = 1'b1;
        end
        if (delay >= 0 && run_cycles - 1 == delay) begin
          check_done = 1'b1;
          check_killed = killed;
          done_sent = 1'b1;
        end
      end else if (done_sent) begin
        check_done = 1'b0;
        check_killed = 1'b0;
      end
      tick();
    end
    frame_tick = 1'b0;
    new_wave = 1'b0;
    check_done = 1'b0;
    check_killed = 1'b0;
    if (!ended) begin
      total++;
      bad++;
      $display("FAIL busy_bound: got busy=%0b want 0 within 80 cycles", busy);
    end
  endtask

  task automatic sb_check(input string name, input int hits);
    exp_t e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s_sb_empty: got empty queue want entry", name);
    end else begin
      e = sb_q.pop_front();
      chk({name, "_mask"},  32'(alive_mask), 32'(e.mask));
      chk({name, "_score"}, 32'(score),      32'(e.score));
      chk({name, "_kills"}, 32'(kill_count), 32'(e.kills));
      chk({name, "_hits"},  32'(hits),       32'(e.hits));
      chk({name, "_idle"},  32'(busy),       32'd0);
      chk({name, "_hold"},  32'(alien_check_reset), 32'd1);
    end
  endtask

  task automatic reset_values(input string name);
    chk({name, "_mask"},  32'(alive_mask),        32'h000F_FFFF);
    chk({name, "_score"}, 32'(score),             32'd0);
    chk({name, "_kills"}, 32'(kill_count),        32'd0);
    chk({name, "_busy"},  32'(busy),              32'd0);
    chk({name, "_hold"},  32'(alien_check_reset), 32'd1);
    chk({name, "_hit"},   32'(laser_hit),         32'd0);
    chk({name, "_ovr"},   32'(frame_overrun),     32'd0);
    chk({name, "_tmo"},   32'(check_timeout),     32'd0);
  endtask

  // Drive a frame up to the first S_RUN cycle.
  task automatic go_to_run(input logic [4:0] idx);
    laser_active = 1'b1;
    which_alien_out = idx;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    tick();
    chk("to_run_busy", 32'(busy), 32'd1);
    chk("to_run_hold", 32'(alien_check_reset), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200us");
    $fatal(1);
  end

  initial begin
    int hits;
    int runs;
    exp_t e;
    logic [19:0] m_mask;
    logic [11:0] m_score;
    logic [4:0]  m_kills;

    vecs[0] = '{1'b1, 2, 1'b1, 5'd7,  20'hFFF7F, 12'd10, 5'd1, 1};
    vecs[1] = '{1'b0, 0, 1'b1, 5'd7,  20'hFFF7F, 12'd10, 5'd1, 0};
    vecs[2] = '{1'b1, 0, 1'b0, 5'd3,  20'hFFF7F, 12'd10, 5'd1, 0};
    vecs[3] = '{1'b1, 1, 1'b1, 5'd7,  20'hFFF7F, 12'd10, 5'd1, 0};
    vecs[4] = '{1'b1, 3, 1'b1, 5'd25, 20'hFFF7F, 12'd10, 5'd1, 0};
    vecs[5] = '{1'b1, 0, 1'b1, 5'd0,  20'hFFF7E, 12'd20, 5'd2, 1};
    vecs[6] = '{1'b1, 5, 1'b1, 5'd19, 20'h7FF7E, 12'd30, 5'd3, 1};

    reset = 1'b1;
    frame_tick = 1'b0;
    laser_active = 1'b0;
    new_wave = 1'b0;
    which_alien_out = 5'd0;
    check_done = 1'b0;
    check_killed = 1'b0;
    #1;
    reset_values("reset");
    #20;
    reset = 1'b0;
    tick();
    reset_values("post_reset");

    for (int v = 0; v < 7; v++) begin
      e.mask = vecs[v].mask;
      e.score = vecs[v].score;
      e.kills = vecs[v].kills;
      e.hits = vecs[v].hits;
      sb_q.push_back(e);
      do_frame(vecs[v].la, vecs[v].delay, vecs[v].killed, vecs[v].idx, 1'b0, hits, runs);
      sb_check($sformatf("vec%0d", v), hits);
    end

    which_alien_out = 5'd7;  #1; chk("alive_7",  32'(alien_alive), 32'd0);
    which_alien_out = 5'd8;  #1; chk("alive_8",  32'(alien_alive), 32'd1);
    which_alien_out = 5'd19; #1; chk("alive_19", 32'(alien_alive), 32'd0);
    which_alien_out = 5'd25; #1; chk("alive_25", 32'(alien_alive), 32'd0);

    m_mask = 20'h7FF7E;
    m_score = 12'd30;
    m_kills = 5'd3;
    for (int i = 1; i < 19; i++) begin
      if (i != 7) begin
        m_mask[i] = 1'b0;
        m_score = m_score + 12'd10;
        m_kills = m_kills + 5'd1;
        e.mask = m_mask;
        e.score = m_score;
        e.kills = m_kills;
        e.hits = 1;
        sb_q.push_back(e);
        do_frame(1'b1, i % 4, 1'b1, 5'(i), 1'b0, hits, runs);
        sb_check($sformatf("sweep%0d", i), hits);
      end
    end
    chk("all_dead", 32'(all_dead), 32'd1);
    chk("full_score", 32'(score), 32'd200);

    e.mask = 20'h0;
    e.score = 12'd200;
    e.kills = 5'd20;
    e.hits = 0;
    sb_q.push_back(e);
    do_frame(1'b1, 0, 1'b1, 5'd0, 1'b0, hits, runs);
    sb_check("dead_frame", hits);
    chk("dead_frame_runs", 32'(runs), 32'd0);

    new_wave = 1'b1;
    tick();
    new_wave = 1'b0;
    chk("wave_mask",  32'(alive_mask), 32'h000F_FFFF);
    chk("wave_kills", 32'(kill_count), 32'd0);
    chk("wave_score", 32'(score),      32'd200);
    chk("wave_dead",  32'(all_dead),   32'd0);

    e.mask = 20'hFFFEF;
    e.score = 12'd210;
    e.kills = 5'd1;
    e.hits = 1;
    sb_q.push_back(e);
    do_frame(1'b1, 1, 1'b1, 5'd4, 1'b0, hits, runs);
    sb_check("kill4", hits);
    chk("pre_ovr", 32'(frame_overrun), 32'd0);
    chk("pre_tmo", 32'(check_timeout), 32'd0);

    do_frame(1'b1, -1, 1'b0, 5'd2, 1'b1, hits, runs);
    chk("tmo_runs", 32'(runs), 32'd32);
    chk("tmo_hits", 32'(hits), 32'd0);
    chk("tmo_flag", 32'(check_timeout), 32'd1);
    chk("ovr_flag", 32'(frame_overrun), 32'd1);
    chk("pending_not_yet", 32'(alive_mask), 32'h000F_FFEF);
    tick();
    chk("pending_mask",  32'(alive_mask), 32'h000F_FFFF);
    chk("pending_kills", 32'(kill_count), 32'd0);
    chk("pending_score", 32'(score),      32'd210);

    go_to_run(5'd5);
    check_done = 1'b1;
    check_killed = 1'b1;
    reset = 1'b1;
    #1;
    reset_values("rst_run");
    check_done = 1'b0;
    check_killed = 1'b0;
    #2;
    reset = 1'b0;
    tick();
    tick();
    reset_values("rst_run_after");

    go_to_run(5'd5);
    check_done = 1'b1;
    check_killed = 1'b1;
    tick();
    check_done = 1'b0;
    check_killed = 1'b0;
    chk("kill_hit", 32'(laser_hit), 32'd1);
    reset = 1'b1;
    #1;
    reset_values("rst_kill");
    #2;
    reset = 1'b0;
    tick();
    tick();
    reset_values("rst_kill_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
